// File: rtl/syndrome_ctrl.sv
// syndrome_ctrl: frame sequencer for a 32-bit-parallel BCH(8191,8087,t=8) syndrome unit.
// Streams one codeword into the accumulators, captures S1..S16 and hands them downstream.
module syndrome_ctrl #(
    parameter int CODE_LENGTH = 8191,
    parameter int PARALLEL    = 32,
    parameter int M           = 13,
    parameter int NSYN        = 16,
    parameter int SYN_LAT     = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [PARALLEL-1:0] in_data,
    input  logic                in_valid,
    input  logic                in_last,
    output logic                in_ready,
    output logic                syn_clr,
    output logic                syn_en,
    output logic [PARALLEL-1:0] syn_r,
    input  logic [NSYN*M-1:0]   syn_s,
    output logic [NSYN*M-1:0]   out_s,
    output logic                out_err,
    output logic                out_ferr,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [15:0]         err_cnt
);
    localparam int WORDS   = (CODE_LENGTH + PARALLEL) / PARALLEL;
    localparam int CNT_W   = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int DRAIN_W = (SYN_LAT > 1) ? $clog2(SYN_LAT) : 1;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t             state, state_nx;
    logic [CNT_W-1:0]   count;
    logic [DRAIN_W-1:0] drain_cnt;
    logic               ferr_q;

    logic accept, frame_end, capture, at_last, syn_nonzero;

    assign at_last     = (count == CNT_W'(WORDS - 1));
    assign syn_nonzero = |syn_s;

    // NOTE: every signal driven here gets a default before the case, so no path
    // through the block leaves a value unassigned and no latch can be inferred.
    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        syn_clr   = 1'b0;
        syn_en    = 1'b0;
        syn_r     = '0;
        accept    = 1'b0;
        frame_end = 1'b0;
        capture   = 1'b0;
        unique case (state)
            CLEAR: begin
                // Gated by reset so the clear pulse only fires once reset is released.
                syn_clr  = reset;
                state_nx = LOAD;
            end
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept = 1'b1;
                    syn_en = 1'b1;
                    syn_r  = in_data;
                    // The first bit in time is the pad that rounds 8191 up to 256 words.
                    if (count == '0) syn_r[PARALLEL-1] = 1'b0;
                    if (in_last || at_last) begin
                        frame_end = 1'b1;
                        state_nx  = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (drain_cnt == DRAIN_W'(SYN_LAT - 1)) begin
                    capture  = 1'b1;
                    state_nx = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) state_nx = CLEAR;
            end
            default: state_nx = CLEAR;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= CLEAR;
            count     <= '0;
            drain_cnt <= '0;
            ferr_q    <= 1'b0;
            out_s     <= '0;
            out_err   <= 1'b0;
            out_ferr  <= 1'b0;
            out_valid <= 1'b0;
            err_cnt   <= '0;
        end else begin
            state <= state_nx;

            if (frame_end) begin
                count  <= '0;
                // Length is right only when the marked word is exactly the last one.
                ferr_q <= ~(in_last & at_last);
            end else if (accept) begin
                count <= count + 1'b1;
            end

            if (state == DRAIN) drain_cnt <= capture ? '0 : drain_cnt + 1'b1;

            if (capture) begin
                out_s     <= syn_s;
                out_ferr  <= ferr_q;
                out_err   <= ~ferr_q & syn_nonzero;
                out_valid <= 1'b1;
                if (~ferr_q && syn_nonzero && (err_cnt != 16'hFFFF)) err_cnt <= err_cnt + 16'd1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_syndrome_ctrl.sv
// tb_syndrome_ctrl: drives codeword frames into syndrome_ctrl with a GF(2^13) syndrome-unit
// model attached, and scores captured syndromes against a direct power-sum evaluation.
module tb_syndrome_ctrl;
    localparam int P     = 32;
    localparam int M     = 13;
    localparam int NSYN  = 16;
    localparam int SW    = NSYN * M;
    localparam int WORDS = 256;
    localparam int NORD  = 8191;

    logic          clk       = 1'b0;
    logic          reset     = 1'b0;
    logic [P-1:0]  in_data   = '0;
    logic          in_valid  = 1'b0;
    logic          in_last   = 1'b0;
    logic          out_ready = 1'b0;
    logic          in_ready, syn_clr, syn_en, out_err, out_ferr, out_valid;
    logic [P-1:0]  syn_r;
    logic [SW-1:0] syn_s, out_s;
    logic [15:0]   err_cnt;

    syndrome_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_last  (in_last),
        .in_ready (in_ready),
        .syn_clr  (syn_clr),
        .syn_en   (syn_en),
        .syn_r    (syn_r),
        .syn_s    (syn_s),
        .out_s    (out_s),
        .out_err  (out_err),
        .out_ferr (out_ferr),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .err_cnt  (err_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // GF(2^13) tables, field polynomial x^13+x^4+x^3+x+1
    int alog [0:NORD-1];
    int glog [0:NORD];

    function automatic void init_gf();
        int x;
        x = 1;
        for (int i = 0; i < NORD; i++) begin
            alog[i] = x;
            glog[x] = i;
            x = x << 1;
            if ((x & 'h2000) != 0) x = x ^ 'h201B;
        end
    endfunction

    function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, input logic [M-1:0] b);
        if (a == '0 || b == '0) return '0;
        return M'(alog[(glog[a] + glog[b]) % NORD]);
    endfunction

    // Syndrome unit model: word-serial Horner update, S_j <- S_j*a^(32j) + sum r_i*a^(ij)
    function automatic logic [M-1:0] horner(input logic [M-1:0] a, input logic [P-1:0] w, input int j);
        logic [M-1:0] r;
        r = gf_mul(a, M'(alog[(P * j) % NORD]));
        for (int i = 0; i < P; i++)
            if (w[i]) r = r ^ M'(alog[(i * j) % NORD]);
        return r;
    endfunction

    logic [M-1:0] acc [NSYN];
    always @(posedge clk) begin
        for (int j = 0; j < NSYN; j++) begin
            if (syn_clr)     acc[j] <= '0;
            else if (syn_en) acc[j] <= horner(acc[j], syn_r, j + 1);
        end
    end

    always_comb begin
        syn_s = '0;
        for (int j = 0; j < NSYN; j++) syn_s[j*M +: M] = acc[j];
    end

    // Frame under test; word 0 bit 31 is the pad position (degree 8191).
    logic [P-1:0] frame [WORDS];

    function automatic void clear_frame();
        for (int w = 0; w < WORDS; w++) frame[w] = '0;
    endfunction

    function automatic void set_deg(input int deg);
        frame[WORDS-1-deg/P][deg%P] = 1'b1;
    endfunction

    function automatic void set_random_bits(input int n);
        for (int k = 0; k < n; k++) set_deg(int'($urandom_range(0, NORD - 1)));
    endfunction

    // Expected syndromes by direct evaluation S_j = sum over set bits of a^(deg*j)
    function automatic logic [SW-1:0] direct_syn();
        logic [SW-1:0] s;
        int deg;
        s = '0;
        for (int w = 0; w < WORDS; w++)
            for (int i = 0; i < P; i++)
                if (frame[w][i] && !(w == 0 && i == P - 1)) begin
                    deg = (WORDS - 1 - w) * P + i;
                    for (int j = 1; j <= NSYN; j++) s[(j-1)*M +: M] = s[(j-1)*M +: M] ^ M'(alog[(deg * j) % NORD]);
                end
        return s;
    endfunction

    typedef struct {
        logic [SW-1:0] s;
        logic          err;
        logic          ferr;
        logic          chk_s;
    } exp_t;

    exp_t        sb [$];
    logic [15:0] exp_cnt = '0;
    int          acc_cyc = 0;
    int          first_acc_cyc = 0;
    int          hs_cyc = 0;

    task automatic send_frame(input int nwords, input int last_idx, input bit stall, input bit push);
        exp_t         e;
        int           idx;
        int           guard;
        logic [P-1:0] exp_r;
        logic         exp_en;
        if (push) begin
            e.ferr  = !(nwords == WORDS && last_idx == WORDS - 1);
            e.s     = direct_syn();
            e.err   = !e.ferr && (e.s != '0);
            e.chk_s = !e.ferr;
            sb.push_back(e);
        end
        idx   = 0;
        guard = 0;
        while (idx < nwords && guard < 8 * WORDS) begin
            @(negedge clk);
            guard++;
            if (stall && $urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                in_data  = $urandom;
                in_last  = 1'($urandom_range(0, 1));
            end else begin
                in_valid = 1'b1;
                in_data  = frame[idx];
                in_last  = (idx == last_idx);
            end
            #1;
            exp_en = in_valid && in_ready;
            exp_r  = '0;
            if (exp_en) begin
                exp_r = frame[idx];
                if (idx == 0) exp_r[P-1] = 1'b0;
            end
            checks++;
            if (syn_en !== exp_en) begin
                errors++;
                $display("FAIL syn_en word %0d: got %b expected %b", idx, syn_en, exp_en);
            end
            checks++;
            if (syn_r !== exp_r) begin
                errors++;
                $display("FAIL syn_r word %0d: got %h expected %h", idx, syn_r, exp_r);
            end
            if (exp_en) begin
                if (idx == 0) first_acc_cyc = cyc;
                acc_cyc = cyc;
                idx++;
            end
        end
        checks++;
        if (idx != nwords) begin
            errors++;
            $display("FAIL send_timeout: got %0d words accepted expected %0d", idx, nwords);
        end
    endtask

    task automatic recv_frame(input int hold);
        exp_t e;
        int   guard;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = $urandom;
        in_last  = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0 || syn_en !== 1'b0) begin
            errors++;
            $display("FAIL drain_ignores_input: got ready=%b en=%b expected 0 0", in_ready, syn_en);
        end
        guard = 0;
        while (out_valid !== 1'b1 && guard < 20) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_last  = 1'b0;
            guard++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL out_valid_timeout: got %b expected 1", out_valid);
            return;
        end
        checks++;
        if (cyc - acc_cyc != 2) begin
            errors++;
            $display("FAIL latency: got %0d expected 2", cyc - acc_cyc);
        end
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: got 0 entries expected 1");
            return;
        end
        e = sb.pop_front();
        if (e.err && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
        for (int k = 0; k <= hold; k++) begin
            if (k > 0) @(negedge clk);
            out_ready = (k == hold);
            checks++;
            if (out_valid !== 1'b1) begin
                errors++;
                $display("FAIL out_valid_hold c%0d: got %b expected 1", k, out_valid);
            end
            checks++;
            if (out_ferr !== e.ferr) begin
                errors++;
                $display("FAIL out_ferr c%0d: got %b expected %b", k, out_ferr, e.ferr);
            end
            checks++;
            if (out_err !== e.err) begin
                errors++;
                $display("FAIL out_err c%0d: got %b expected %b", k, out_err, e.err);
            end
            checks++;
            if (err_cnt !== exp_cnt) begin
                errors++;
                $display("FAIL err_cnt c%0d: got %h expected %h", k, err_cnt, exp_cnt);
            end
            if (e.chk_s) begin
                checks++;
                if (out_s !== e.s) begin
                    errors++;
                    $display("FAIL out_s c%0d: got %h expected %h", k, out_s, e.s);
                end
            end
        end
        hs_cyc = cyc;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || syn_clr !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL after_handshake: got valid=%b clr=%b ready=%b expected 0 1 0", out_valid, syn_clr, in_ready);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if ({out_valid, out_err, out_ferr, in_ready, syn_en, syn_clr} !== 6'b0) begin
            errors++;
            $display("FAIL %s_ctrl: got %b expected 000000", tag, {out_valid, out_err, out_ferr, in_ready, syn_en, syn_clr});
        end
        checks++;
        if (out_s !== '0 || syn_r !== '0) begin
            errors++;
            $display("FAIL %s_data: got out_s=%h syn_r=%h expected 0", tag, out_s, syn_r);
        end
        checks++;
        if (err_cnt !== 16'h0) begin
            errors++;
            $display("FAIL %s_err_cnt: got %h expected 0000", tag, err_cnt);
        end
    endtask

    task automatic test_reset();
        in_valid = 1'b1;
        in_data  = 32'hFFFF_FFFF;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset    = 1'b1;
        in_valid = 1'b0;
        #1;
        checks++;
        if (syn_clr !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL clear_after_reset: got clr=%b ready=%b expected 1 0", syn_clr, in_ready);
        end
    endtask

    task automatic test_zero_frame();
        clear_frame();
        send_frame(WORDS, WORDS - 1, 1'b0, 1'b1);
        recv_frame(0);
    endtask

    task automatic test_single_error();
        clear_frame();
        set_deg(0);
        send_frame(WORDS, WORDS - 1, 1'b0, 1'b1);
        recv_frame(1);
    endtask

    task automatic test_pad_bit();
        clear_frame();
        frame[0][P-1] = 1'b1;
        send_frame(WORDS, WORDS - 1, 1'b0, 1'b1);
        recv_frame(0);
    endtask

    task automatic test_stalls();
        for (int f = 0; f < 2; f++) begin
            clear_frame();
            set_random_bits(24);
            send_frame(WORDS, WORDS - 1, 1'b1, 1'b1);
            recv_frame(5);
        end
    endtask

    task automatic test_length_errors();
        clear_frame();
        set_random_bits(40);
        send_frame(101, 100, 1'b0, 1'b1);
        recv_frame(2);
        send_frame(WORDS, -1, 1'b1, 1'b1);
        recv_frame(0);
        clear_frame();
        set_random_bits(5);
        send_frame(WORDS, WORDS - 1, 1'b0, 1'b1);
        recv_frame(0);
    endtask

    task automatic test_back_to_back();
        clear_frame();
        set_random_bits(3);
        send_frame(WORDS, WORDS - 1, 1'b0, 1'b1);
        recv_frame(0);
        clear_frame();
        set_random_bits(7);
        send_frame(WORDS, WORDS - 1, 1'b0, 1'b1);
        checks++;
        if (first_acc_cyc - hs_cyc != 2) begin
            errors++;
            $display("FAIL restart_gap: got %0d expected 2", first_acc_cyc - hs_cyc);
        end
        recv_frame(0);
    endtask

    task automatic test_reset_mid_frame();
        clear_frame();
        set_random_bits(30);
        send_frame(130, -1, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = frame[130];
        #2;
        reset = 1'b0;
        #1;
        check_reset_outputs("reset_mid");
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        reset    = 1'b1;
        exp_cnt  = '0;
        clear_frame();
        set_random_bits(12);
        send_frame(WORDS, WORDS - 1, 1'b1, 1'b1);
        recv_frame(1);
    endtask

    task automatic test_saturation();
        force dut.err_cnt = 16'hFFFF;
        #1;
        release dut.err_cnt;
        exp_cnt = 16'hFFFF;
        #1;
        checks++;
        if (err_cnt !== 16'hFFFF) begin
            errors++;
            $display("FAIL err_cnt_preload: got %h expected ffff", err_cnt);
        end
        clear_frame();
        set_deg(777);
        send_frame(WORDS, WORDS - 1, 1'b0, 1'b1);
        recv_frame(0);
    endtask

    initial begin
        init_gf();
        test_reset();
        test_zero_frame();
        test_single_error();
        test_pad_bit();
        test_stalls();
        test_length_errors();
        test_back_to_back();
        test_reset_mid_frame();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
